// File: rtl/alu_ctrl_seq.sv
// Issue side of the ALU: decodes ALU_OP/FUNCT, holds operands for the op latency,
// captures OPS/ZF and hands the result back over a valid/ready handshake.
module alu_ctrl_seq #(
    parameter int BASE_LAT = 1,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [1:0]  ALU_OP,
    input  logic [5:0]  FUNCT,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] OP1,
    output logic [31:0] OP2,
    output logic [2:0]  OP,
    input  logic [31:0] OPS,
    input  logic        ZF,
    output logic        RES_VALID,
    input  logic        OUT_READY,
    output logic [31:0] RES,
    output logic        RES_ZF,
    output logic        ILLEGAL,
    output logic        DIVZ
);
    // state | meaning
    // IDLE  | ready for a request
    // EXEC  | operands held on the ALU, counting down the latency
    // DONE  | result presented, waiting for OUT_READY
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ?
                             ((MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT) :
                             ((DIV_LAT > BASE_LAT) ? DIV_LAT : BASE_LAT);
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_op1;
    logic [31:0]        r_op2;
    logic [2:0]         r_op;
    logic [31:0]        r_res;
    logic               r_res_zf;
    logic               r_res_valid;
    logic               r_illegal;
    logic               r_divz;
    logic [2:0]         w_code;
    logic               w_illegal;
    logic               w_divz;
    int                 w_lat;
    logic [CNT_W-1:0]   w_cnt_init;

    always_comb begin
        w_code    = 3'b110;
        w_illegal = 1'b0;
        w_divz    = 1'b0;
        unique case (ALU_OP)
            2'b00: w_code = 3'b010;
            2'b01: w_code = 3'b011;
            2'b11: w_code = 3'b100;
            default: begin
                case (FUNCT)
                    6'b100100: w_code = 3'b000;
                    6'b100101: w_code = 3'b001;
                    6'b100000: w_code = 3'b010;
                    6'b100010: w_code = 3'b011;
                    6'b101010: w_code = 3'b100;
                    6'b011010: w_code = 3'b101;
                    6'b011000: w_code = 3'b111;
                    6'b000000: w_code = 3'b110;
                    default:   w_illegal = 1'b1;
                endcase
            end
        endcase
        // Divide by zero is redirected to the ALU's zero op at base latency.
        if (w_code == 3'b101 && B == 32'd0) begin
            w_code = 3'b110;
            w_divz = 1'b1;
        end
        case (w_code)
            3'b111:  w_lat = MUL_LAT;
            3'b101:  w_lat = DIV_LAT;
            default: w_lat = BASE_LAT;
        endcase
        w_cnt_init = CNT_W'(w_lat - 1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        IN_READY    = 1'b0;
        case (r_state)
            IDLE: begin
                IN_READY = !RST;
                if (IN_VALID) w_state_nxt = w_illegal ? DONE : EXEC;
            end
            EXEC: if (r_cnt == '0) w_state_nxt = DONE;
            DONE: if (OUT_READY) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt       <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_op        <= 3'b110;
            r_res       <= '0;
            r_res_zf    <= 1'b0;
            r_res_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_divz      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (IN_VALID) begin
                    if (w_illegal) begin
                        r_res       <= '0;
                        r_res_zf    <= 1'b0;
                        r_illegal   <= 1'b1;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_op1  <= A;
                        r_op2  <= B;
                        r_op   <= w_code;
                        r_divz <= w_divz;
                        r_cnt  <= w_cnt_init;
                    end
                end
                EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_res       <= OPS;
                        r_res_zf    <= ZF;
                        r_res_valid <= 1'b1;
                    end
                end
                DONE: if (OUT_READY) begin
                    r_res_valid <= 1'b0;
                    r_illegal   <= 1'b0;
                    r_divz      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign OP1       = r_op1;
    assign OP2       = r_op2;
    assign OP        = r_op;
    assign RES       = r_res;
    assign RES_ZF    = r_res_zf;
    assign RES_VALID = r_res_valid;
    assign ILLEGAL   = r_illegal;
    assign DIVZ      = r_divz;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized bench for alu_ctrl_seq: behavioural ALU on the OP side and a
// request-level reference model predicting result, flags, code and latency.
module tb_alu_ctrl_seq;
    localparam int BASE_LAT = 1;
    localparam int MUL_LAT  = 4;
    localparam int DIV_LAT  = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [1:0]  ALU_OP;
    logic [5:0]  FUNCT;
    logic [31:0] A, B;
    logic [31:0] OP1, OP2;
    logic [2:0]  OP;
    logic [31:0] OPS;
    logic        ZF;
    logic        RES_VALID;
    logic        OUT_READY;
    logic [31:0] RES;
    logic        RES_ZF;
    logic        ILLEGAL;
    logic        DIVZ;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_op1, last_op2;
    logic [2:0]  last_op;

    typedef struct {
        bit          illegal;
        bit          divz;
        logic [2:0]  code;
        logic [31:0] res;
        bit          zf;
        int          lat;
    } exp_t;

    alu_ctrl_seq #(.BASE_LAT(BASE_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .ALU_OP(ALU_OP), .FUNCT(FUNCT), .A(A), .B(B),
        .OP1(OP1), .OP2(OP2), .OP(OP), .OPS(OPS), .ZF(ZF),
        .RES_VALID(RES_VALID), .OUT_READY(OUT_READY), .RES(RES), .RES_ZF(RES_ZF),
        .ILLEGAL(ILLEGAL), .DIVZ(DIVZ)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU driven by the block under test.
    always_comb begin
        OPS = 32'd0;
        case (OP)
            3'b000: OPS = OP1 & OP2;
            3'b001: OPS = OP1 | OP2;
            3'b010: OPS = OP1 + OP2;
            3'b011: OPS = OP1 - OP2;
            3'b100: OPS = {31'd0, $signed(OP1) < $signed(OP2)};
            3'b101: OPS = (OP2 != 0) ? OP1 / OP2 : 32'd0;
            3'b111: OPS = OP1 * OP2;
            default: OPS = 32'd0;
        endcase
        ZF = (OPS == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [1:0] aop, input logic [5:0] f,
                                       input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.illegal = 0; e.divz = 0; e.lat = BASE_LAT; e.code = 3'b110; e.res = 0;
        if (aop == 2'b00)      begin e.code = 3'b010; e.res = a + b; end
        else if (aop == 2'b01) begin e.code = 3'b011; e.res = a - b; end
        else if (aop == 2'b11) begin e.code = 3'b100; e.res = ($signed(a) < $signed(b)) ? 1 : 0; end
        else begin
            case (f)
                6'b100100: begin e.code = 3'b000; e.res = a & b; end
                6'b100101: begin e.code = 3'b001; e.res = a | b; end
                6'b100000: begin e.code = 3'b010; e.res = a + b; end
                6'b100010: begin e.code = 3'b011; e.res = a - b; end
                6'b101010: begin e.code = 3'b100; e.res = ($signed(a) < $signed(b)) ? 1 : 0; end
                6'b011000: begin e.code = 3'b111; e.res = a * b; e.lat = MUL_LAT; end
                6'b011010: begin
                    if (b == 0) begin e.code = 3'b110; e.res = 0; e.divz = 1; end
                    else begin e.code = 3'b101; e.res = a / b; e.lat = DIV_LAT; end
                end
                6'b000000: begin e.code = 3'b110; e.res = 0; end
                default:   begin e.illegal = 1; e.lat = 0; end
            endcase
        end
        e.zf = e.illegal ? 0 : (e.res == 0);
        return e;
    endfunction

    // Issue one request and drain it, stalling the result for `stall` cycles.
    // Entered and left at 1 time unit after a rising edge.
    task automatic do_req(input logic [1:0] aop, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b, input int stall);
        exp_t e;
        int n;
        e = ref_model(aop, f, a, b);
        ALU_OP = aop; FUNCT = f; A = a; B = b; IN_VALID = 1'b1;
        chk("in_ready_idle", {31'd0, IN_READY}, 32'd1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        if (!e.illegal) begin
            last_op1 = a; last_op2 = b; last_op = e.code;
        end
        n = 0;
        while (!RES_VALID && n < 40) begin
            chk("hold_op",  {29'd0, OP}, {29'd0, last_op});
            chk("hold_op1", OP1, last_op1);
            chk("hold_op2", OP2, last_op2);
            chk("exec_ready", {31'd0, IN_READY}, 32'd0);
            IN_VALID = $urandom_range(0, 1); A = $urandom; B = $urandom; ALU_OP = 2'b00;
            @(posedge CLK); #1;
            n++;
        end
        IN_VALID = 1'b0;
        chk("latency", n, e.lat);
        chk("res", RES, e.res);
        chk("res_zf", {31'd0, RES_ZF}, {31'd0, e.zf});
        chk("illegal", {31'd0, ILLEGAL}, {31'd0, e.illegal});
        chk("divz", {31'd0, DIVZ}, {31'd0, e.divz});
        chk("done_op", {29'd0, OP}, {29'd0, last_op});
        chk("done_op1", OP1, last_op1);
        for (int i = 0; i < stall; i++) begin
            OUT_READY = 1'b0; IN_VALID = 1'b1; ALU_OP = 2'b01; A = $urandom; B = $urandom;
            @(posedge CLK); #1;
            chk("stall_valid", {31'd0, RES_VALID}, 32'd1);
            chk("stall_res", RES, e.res);
            chk("stall_ready", {31'd0, IN_READY}, 32'd0);
            chk("stall_op", {29'd0, OP}, {29'd0, last_op});
        end
        // Result handshake with a competing request: only the handshake completes.
        OUT_READY = 1'b1; IN_VALID = 1'b1; ALU_OP = 2'b00; A = $urandom; B = $urandom;
        @(posedge CLK); #1;
        OUT_READY = 1'b0; IN_VALID = 1'b0;
        chk("hs_valid", {31'd0, RES_VALID}, 32'd0);
        chk("hs_flags", {30'd0, ILLEGAL, DIVZ}, 32'd0);
        chk("hs_ready", {31'd0, IN_READY}, 32'd1);
        chk("hs_op1", OP1, last_op1);
        chk("hs_res", RES, e.res);
    endtask

    initial begin
        logic [5:0] legal [8];
        legal = '{6'b100100, 6'b100101, 6'b100000, 6'b100010,
                  6'b101010, 6'b011010, 6'b011000, 6'b000000};
        RST = 1'b1; IN_VALID = 0; OUT_READY = 0; ALU_OP = 0; FUNCT = 0; A = 0; B = 0;
        last_op1 = 0; last_op2 = 0; last_op = 3'b110;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", {31'd0, IN_READY}, 32'd0);
        chk("rst_op", {29'd0, OP}, 32'd6);
        chk("rst_op1", OP1, 32'd0);
        chk("rst_res", RES, 32'd0);
        chk("rst_flags", {29'd0, RES_VALID, ILLEGAL, DIVZ}, 32'd0);
        RST = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, IN_READY}, 32'd1);
        @(posedge CLK); #1;

        do_req(2'b10, 6'b100000, 32'd5, 32'd7, 0);
        do_req(2'b01, 6'b000000, 32'h1234, 32'h1234, 1);
        do_req(2'b10, 6'b011000, 32'd6, 32'd7, 0);
        do_req(2'b10, 6'b011010, 32'd9, 32'd0, 0);
        do_req(2'b10, 6'b111111, 32'd3, 32'd4, 0);
        do_req(2'b10, 6'b011010, 32'd100, 32'd7, 5);
        do_req(2'b11, 6'b000000, 32'hFFFF_FFFF, 32'd1, 0);

        for (int t = 0; t < 60; t++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            int sel;
            sel = $urandom_range(0, 9);
            f = (sel < 8) ? legal[sel] : ((sel == 8) ? 6'($urandom) : 6'b111111);
            a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 50));
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20)));
            do_req(2'($urandom_range(0, 3)), f, a, b, $urandom_range(0, 3));
        end

        // Reset during a divide discards it.
        ALU_OP = 2'b10; FUNCT = 6'b011010; A = 32'd50; B = 32'd5; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_op", {29'd0, OP}, 32'd6);
        chk("mid_rst_op1", OP1, 32'd0);
        chk("mid_rst_ready", {31'd0, IN_READY}, 32'd0);
        chk("mid_rst_flags", {29'd0, RES_VALID, ILLEGAL, DIVZ}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            chk("no_res_after_rst", {31'd0, RES_VALID}, 32'd0);
        end
        chk("idle_after_rst", {31'd0, IN_READY}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Issuing side of the 32-bit ALU interface: decodes main-control ALU_OP plus R-type FUNCT into the ALU's 3-bit OP code and drives OP1/OP2.
- Holds the operands stable for the operation's latency, captures OPS/ZF back from the ALU, and returns them to the datapath over a valid/ready handshake.
- Sits between the decode stage and the ALU instance; one operation in flight at a time.

Parameters:
- BASE_LAT, 1, cycles OP1/OP2/OP are held before capture for AND/OR/ADD/SUB/SLT/ZERO (≥1).
- MUL_LAT, 4, hold cycles for multiply, OP=111 (≥1).
- DIV_LAT, 8, hold cycles for divide, OP=101 (≥1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  block can accept a request.
- ALU_OP  in  2  from main control: 00 add, 01 sub, 10 use FUNCT, 11 slt.
- FUNCT  in  6  R-type function field.
- A  in  32  operand 1.
- B  in  32  operand 2.
- OP1  out  32  to ALU OP1.
- OP2  out  32  to ALU OP2.
- OP  out  3  to ALU OP.
- OPS  in  32  ALU result.
- ZF  in  1  ALU zero flag.
- RES_VALID  out  1  result available.
- OUT_READY  in  1  consumer accepts result.
- RES  out  32  captured result.
- RES_ZF  out  1  captured zero flag.
- ILLEGAL  out  1  request had an undecodable FUNCT.
- DIVZ  out  1  divide requested with B==0.

Behaviour:
- Reset (async, RST=1): state IDLE; IN_READY=0 while RST is high, 1 in the first IDLE cycle after release. OP1=OP2=0, OP=3'b110, RES=0, RES_ZF=0, RES_VALID=0, ILLEGAL=0, DIVZ=0, counter=0. A reset asserted mid-operation discards the in-flight request with no result.
- Decode:
  - ALU_OP 00→010, 01→011, 11→100.
  - ALU_OP 10 with FUNCT: 100100→000, 100101→001, 100000→010, 100010→011, 101010→100, 011010→101, 011000→111, 000000→110.
  - Any other FUNCT under ALU_OP 10 is illegal.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - IN_READY=1. An accept occurs on an edge with IN_VALID=1.
  - Legal request: OP1←A, OP2←B, OP←decoded code, counter←lat−1, go to EXEC.
    - lat is BASE_LAT, MUL_LAT, or DIV_LAT by OP class.
  - Illegal request: RES←0, RES_ZF←0, ILLEGAL←1, go directly to DONE. OP1/OP2/OP are unchanged.
  - Divide with B==0: OP←110 (ALU outputs 0), DIVZ←1, lat=BASE_LAT.
- EXEC:
  - IN_READY=0. OP1/OP2/OP are held constant.
  - While counter≠0, decrement it each cycle.
  - On the edge with counter==0: RES←OPS, RES_ZF←ZF, RES_VALID←1, go to DONE.
  - An accept at edge k gives RES_VALID=1 after edge k+lat.
- DONE:
  - IN_READY=0. RES, RES_ZF, ILLEGAL and DIVZ are held stable while RES_VALID=1 and OUT_READY=0.
  - On an edge with OUT_READY=1: RES_VALID←0, ILLEGAL←0, DIVZ←0, go to IDLE.
  - OP1/OP2/OP keep their last values. RES is retained until the next capture.
- IN_VALID is ignored outside IDLE. No back-to-back issue: minimum spacing between accepts is lat+2 cycles.
- IN_VALID and OUT_READY asserted together in DONE: only the result handshake completes; the new request is accepted in the following IDLE cycle if still valid.
- All arithmetic is performed by the ALU. This block adds no width changes; RES is a 32-bit copy of OPS.

Test Plan:
- Reset then ALU_OP=10, FUNCT=100000, A=5, B=7 → OP=010 one cycle after accept; RES_VALID after 1 edge with RES=12, RES_ZF=0; OUT_READY=1 → IDLE, IN_READY=1.
- ALU_OP=01, A=B=0x1234 → OP=011, RES=0, RES_ZF=1.
- ALU_OP=10, FUNCT=011000, A=6, B=7, MUL_LAT=4 → OP1/OP2/OP=111 held 4 cycles, RES=42 after edge k+4.
- ALU_OP=10, FUNCT=011010, A=9, B=0 → OP=110, DIVZ=1, RES=0, RES_ZF=1.
- FUNCT=111111 with ALU_OP=10 → RES_VALID one edge after accept, ILLEGAL=1, RES=0, OP unchanged.
- Result stall and reset:
  - Hold OUT_READY=0 for 5 cycles with IN_VALID=1 → RES stable, IN_READY=0, no second accept.
  - Assert RST during EXEC of a DIV → all outputs at reset values immediately, no RES_VALID afterwards.
